// File: rtl/pc_epc_unit_if.sv
// Handler-vector read channel between pc_epc_unit and memory.
// The unit is the master; memory acknowledges with data in the same cycle.
interface pc_epc_unit_if;
  logic        w_VecReq;
  logic [31:0] w_VecAddr;
  logic        w_VecAck;
  logic [7:0]  w_VecData;

  modport master (
    output w_VecReq,
    output w_VecAddr,
    input  w_VecAck,
    input  w_VecData
  );

  modport slave (
    input  w_VecReq,
    input  w_VecAddr,
    output w_VecAck,
    output w_VecData
  );
endinterface

// File: rtl/pc_epc_unit.sv
// PC / EPC / Cause registers with exception entry and a handshaked
// handler-vector byte fetch that reloads the PC.
module pc_epc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        w_MUX11,
  input  logic               w_PCWrite,
  input  logic               w_PCWriteCond,
  input  logic               w_Zero,
  input  logic               w_BranchNE,
  input  logic               w_ExcReq,
  input  logic [1:0]         w_ExcCode,
  pc_epc_unit_if.master      vec,
  output logic [31:0]        w_PC,
  output logic [31:0]        w_EPC,
  output logic [31:0]        w_Cause,
  output logic               w_ExcBusy
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FETCH,
    S_LOAD
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;
  logic [1:0]  r_code;
  logic [7:0]  r_byte;

  logic        w_pc_en;
  logic        w_run;
  logic        w_exc;
  logic        w_run_wr;
  logic        w_load;
  logic        w_cap;
  logic [1:0]  w_code;
  logic [31:0] w_pc_nxt;

  assign w_pc_en  = w_PCWrite |
                    (w_PCWriteCond & (w_Zero ^ w_BranchNE));
  assign w_run    = (r_state == S_RUN);
  assign w_exc    = w_run & w_ExcReq;
  assign w_run_wr = w_run & ~w_ExcReq & w_pc_en;
  assign w_load   = (r_state == S_LOAD);
  assign w_cap    = (r_state == S_FETCH) & vec.w_VecAck;
  // Reserved code 11 is treated as an invalid-opcode exception.
  assign w_code   = (w_ExcCode == 2'b11) ? 2'b00 : w_ExcCode;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (w_ExcReq) w_next = S_FETCH;
      S_FETCH: if (vec.w_VecAck) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    unique case (1'b1)
      w_load:   w_pc_nxt = {24'b0, r_byte};
      w_run_wr: w_pc_nxt = w_MUX11;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc   <= '0;
      r_cause <= '0;
      r_code  <= '0;
    end else if (w_exc) begin
      r_epc   <= r_pc - 32'd4;
      r_cause <= w_code;
      r_code  <= w_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_byte <= '0;
    else if (w_cap) r_byte <= vec.w_VecData;
  end

  assign vec.w_VecReq  = (r_state == S_FETCH);
  assign vec.w_VecAddr = VEC_BASE + {30'b0, r_code};

  assign w_PC      = r_pc;
  assign w_EPC     = r_epc;
  assign w_Cause   = {30'b0, r_cause};
  assign w_ExcBusy = ~w_run;

endmodule

// File: tb/tb_pc_epc_unit.sv
// Directed bench for pc_epc_unit: PC-write vectors plus exception,
// busy-ignore and reset-mid-fetch sequences.
module tb_pc_epc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] w_MUX11;
  logic        w_PCWrite;
  logic        w_PCWriteCond;
  logic        w_Zero;
  logic        w_BranchNE;
  logic        w_ExcReq;
  logic [1:0]  w_ExcCode;
  logic [31:0] w_PC;
  logic [31:0] w_EPC;
  logic [31:0] w_Cause;
  logic        w_ExcBusy;

  int checks   = 0;
  int failures = 0;

  pc_epc_unit_if vif();

  pc_epc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w_MUX11       (w_MUX11),
    .w_PCWrite     (w_PCWrite),
    .w_PCWriteCond (w_PCWriteCond),
    .w_Zero        (w_Zero),
    .w_BranchNE    (w_BranchNE),
    .w_ExcReq      (w_ExcReq),
    .w_ExcCode     (w_ExcCode),
    .vec           (vif.master),
    .w_PC          (w_PC),
    .w_EPC         (w_EPC),
    .w_Cause       (w_Cause),
    .w_ExcBusy     (w_ExcBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mux;
    logic        pcw;
    logic        pcwc;
    logic        zero;
    logic        bne;
    logic        ack;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_MUX11       = '0;
    w_PCWrite     = 1'b0;
    w_PCWriteCond = 1'b0;
    w_Zero        = 1'b0;
    w_BranchNE    = 1'b0;
    w_ExcReq      = 1'b0;
    w_ExcCode     = 2'b00;
    vif.w_VecAck  = 1'b0;
    vif.w_VecData = 8'h00;
  endtask

  initial begin
    tbl[0] = '{32'h4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4};
    tbl[1] = '{32'h8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4};
    tbl[2] = '{32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40};
    tbl[3] = '{32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40};
    tbl[4] = '{32'h48, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h48};
    tbl[5] = '{32'h4C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h48};
    tbl[6] = '{32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h48};
    tbl[7] = '{32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_pc",    w_PC, 32'h0);
    chk("rst_epc",   w_EPC, 32'h0);
    chk("rst_cause", w_Cause, 32'h0);
    chk("rst_req",   {31'b0, vif.w_VecReq}, 32'h0);
    chk("rst_addr",  vif.w_VecAddr, 32'd253);
    chk("rst_busy",  {31'b0, w_ExcBusy}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      w_MUX11       = tbl[i].mux;
      w_PCWrite     = tbl[i].pcw;
      w_PCWriteCond = tbl[i].pcwc;
      w_Zero        = tbl[i].zero;
      w_BranchNE    = tbl[i].bne;
      vif.w_VecAck  = tbl[i].ack;
      vif.w_VecData = 8'hEE;
      tick();
      chk($sformatf("vec%0d_pc", i), w_PC, tbl[i].exp_pc);
      chk($sformatf("vec%0d_busy", i),
          {31'b0, w_ExcBusy}, 32'h0);
    end
    idle();

    // Overflow exception with a competing PC write in the same cycle
    w_ExcReq  = 1'b1;
    w_ExcCode = 2'b01;
    w_PCWrite = 1'b1;
    w_MUX11   = 32'h100;
    tick();
    idle();
    chk("ov_epc",   w_EPC, 32'h1C);
    chk("ov_cause", w_Cause, 32'h1);
    chk("ov_pc",    w_PC, 32'h20);
    chk("ov_addr",  vif.w_VecAddr, 32'd254);
    chk("ov_req",   {31'b0, vif.w_VecReq}, 32'h1);
    chk("ov_busy",  {31'b0, w_ExcBusy}, 32'h1);

    for (int w = 0; w < 3; w++) begin
      w_ExcReq      = 1'b1;
      w_ExcCode     = 2'b10;
      w_PCWrite     = 1'b1;
      w_MUX11       = 32'h200;
      vif.w_VecData = 8'h55 + 8'(w);
      tick();
      chk($sformatf("wait%0d_pc", w),    w_PC, 32'h20);
      chk($sformatf("wait%0d_epc", w),   w_EPC, 32'h1C);
      chk($sformatf("wait%0d_cause", w), w_Cause, 32'h1);
      chk($sformatf("wait%0d_addr", w),  vif.w_VecAddr, 32'd254);
      chk($sformatf("wait%0d_req", w),
          {31'b0, vif.w_VecReq}, 32'h1);
    end
    idle();

    vif.w_VecAck  = 1'b1;
    vif.w_VecData = 8'hA8;
    tick();
    idle();
    chk("ack_pc",   w_PC, 32'h20);
    chk("ack_busy", {31'b0, w_ExcBusy}, 32'h1);
    chk("ack_req",  {31'b0, vif.w_VecReq}, 32'h0);
    tick();
    chk("load_pc",   w_PC, 32'hA8);
    chk("load_busy", {31'b0, w_ExcBusy}, 32'h0);

    // Code 11 at PC 0, request held high through LOAD
    w_PCWrite = 1'b1;
    w_MUX11   = 32'h0;
    tick();
    idle();
    chk("zero_pc", w_PC, 32'h0);
    w_ExcReq  = 1'b1;
    w_ExcCode = 2'b11;
    tick();
    chk("c3_cause", w_Cause, 32'h0);
    chk("c3_epc",   w_EPC, 32'hFFFF_FFFC);
    chk("c3_addr",  vif.w_VecAddr, 32'd253);
    vif.w_VecAck  = 1'b1;
    vif.w_VecData = 8'h12;
    tick();
    vif.w_VecAck = 1'b0;
    chk("c3_load_busy", {31'b0, w_ExcBusy}, 32'h1);
    tick();
    chk("c3_pc",   w_PC, 32'h12);
    chk("c3_busy", {31'b0, w_ExcBusy}, 32'h0);
    tick();
    idle();
    chk("re_epc",  w_EPC, 32'hE);
    chk("re_busy", {31'b0, w_ExcBusy}, 32'h1);
    chk("re_req",  {31'b0, vif.w_VecReq}, 32'h1);

    // Asynchronous reset in the middle of FETCH
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req",  {31'b0, vif.w_VecReq}, 32'h0);
    chk("mrst_pc",   w_PC, 32'h0);
    chk("mrst_epc",  w_EPC, 32'h0);
    chk("mrst_busy", {31'b0, w_ExcBusy}, 32'h0);
    tick();
    rst_n = 1'b1;
    vif.w_VecAck  = 1'b1;
    vif.w_VecData = 8'h77;
    tick();
    tick();
    idle();
    chk("late_busy", {31'b0, w_ExcBusy}, 32'h0);
    chk("late_req",  {31'b0, vif.w_VecReq}, 32'h0);
    chk("late_pc",   w_PC, 32'h0);

    w_PCWrite = 1'b1;
    w_MUX11   = 32'h30;
    tick();
    idle();
    chk("post_pc", w_PC, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
